// File: rtl/led_sequencer.sv
// LED pattern generator: chase, bounce, breathe (PWM) and static modes, stepped
// by a free-running prescaler, with a ready/valid mode request applied on a step.
module led_sequencer #(
    parameter int NUM_LEDS      = 4,
    parameter int PRESCALE_BITS = 21,
    parameter int PWM_BITS      = 8,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          mode_in,
    input  logic                mode_valid,
    output logic                mode_ready,
    input  logic [NUM_LEDS-1:0] pattern_in,
    output logic                step_tick,
    output logic [NUM_LEDS-1:0] leds
);
    localparam int POS_BITS = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [POS_BITS-1:0]      POS_ONE   = POS_BITS'(1);
    localparam logic [POS_BITS-1:0]      POS_LAST  = POS_BITS'(NUM_LEDS - 1);
    localparam logic [PWM_BITS-1:0]      PWM_ONE   = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0]      DUTY_MAX  = '1;
    localparam logic [PRESCALE_BITS-1:0] PRE_ONE   = PRESCALE_BITS'(1);
    localparam logic [NUM_LEDS-1:0]      LIT_FIRST = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0]      LED_RESET = ACTIVE_LOW ? ~LIT_FIRST : LIT_FIRST;

    typedef enum logic [1:0] {
        MODE_CHASE   = 2'd0,
        MODE_BOUNCE  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_STATIC  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PRESCALE_BITS-1:0] prescaler, prescaler_next;
    logic [PWM_BITS-1:0]      pwm_cnt, pwm_cnt_next;
    logic [PWM_BITS-1:0]      duty, duty_next;
    logic [POS_BITS-1:0]      pos, pos_next;
    dir_t                     dir, dir_next;
    mode_t                    mode, mode_next;
    logic [NUM_LEDS-1:0]      pattern, pattern_next;
    logic                     pending, pending_next;
    mode_t                    pend_mode, pend_mode_next;
    logic [NUM_LEDS-1:0]      pend_pattern, pend_pattern_next;
    logic                     step_tick_next;
    logic [NUM_LEDS-1:0]      lit, leds_next;
    logic                     tick;
    logic                     accept;

    assign tick       = (prescaler == '1);
    assign accept     = mode_valid & ~pending;
    assign mode_ready = ~pending;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            duty         <= '0;
            pos          <= '0;
            dir          <= DIR_UP;
            mode         <= MODE_CHASE;
            pattern      <= '0;
            pending      <= 1'b0;
            pend_mode    <= MODE_CHASE;
            pend_pattern <= '0;
            step_tick    <= 1'b0;
            leds         <= LED_RESET;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            prescaler    <= prescaler_next;
            pwm_cnt      <= pwm_cnt_next;
            duty         <= duty_next;
            pos          <= pos_next;
            dir          <= dir_next;
            mode         <= mode_next;
            pattern      <= pattern_next;
            pending      <= pending_next;
            pend_mode    <= pend_mode_next;
            pend_pattern <= pend_pattern_next;
            step_tick    <= step_tick_next;
            leds         <= leds_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every target gets a hold default first so no path can infer a latch.
        prescaler_next    = prescaler + PRE_ONE;
        pwm_cnt_next      = pwm_cnt + PWM_ONE;
        step_tick_next    = tick;
        duty_next         = duty;
        pos_next          = pos;
        dir_next          = dir;
        mode_next         = mode;
        pattern_next      = pattern;
        pending_next      = pending;
        pend_mode_next    = pend_mode;
        pend_pattern_next = pend_pattern;

        if (tick) begin
            if (pending) begin
                mode_next    = pend_mode;
                pattern_next = pend_pattern;
                pos_next     = '0;
                dir_next     = DIR_UP;
                duty_next    = '0;
                pending_next = 1'b0;
            end else begin
                case (mode)
                    MODE_CHASE: begin
                        pos_next = (pos == POS_LAST) ? '0 : pos + POS_ONE;
                    end
                    MODE_BOUNCE: begin
                        if (NUM_LEDS == 1) begin
                            pos_next = '0;
                        end else if (dir == DIR_UP) begin
                            if (pos == POS_LAST) begin
                                dir_next = DIR_DOWN;
                                pos_next = pos - POS_ONE;
                            end else begin
                                pos_next = pos + POS_ONE;
                            end
                        end else begin
                            if (pos == '0) begin
                                dir_next = DIR_UP;
                                pos_next = pos + POS_ONE;
                            end else begin
                                pos_next = pos - POS_ONE;
                            end
                        end
                    end
                    MODE_BREATHE: begin
                        // Each end value is held for one extra step while dir turns.
                        if (dir == DIR_UP) begin
                            if (duty == DUTY_MAX) dir_next = DIR_DOWN;
                            else                  duty_next = duty + PWM_ONE;
                        end else begin
                            if (duty == '0) dir_next = DIR_UP;
                            else            duty_next = duty - PWM_ONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        // A request accepted on a tick edge waits for the following tick.
        if (accept) begin
            pending_next      = 1'b1;
            pend_mode_next    = mode_t'(mode_in);
            pend_pattern_next = pattern_in;
        end
    end

    // Output logic: lit pattern from current state, polarity applied before the register.
    always_comb begin
        lit = '0;
        case (mode)
            MODE_CHASE,
            MODE_BOUNCE:  lit = LIT_FIRST << pos;
            MODE_BREATHE: lit = {NUM_LEDS{pwm_cnt < duty}};
            default:      lit = pattern;
        endcase
        leds_next = ACTIVE_LOW ? ~lit : lit;
    end

endmodule
